// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared widths, beat index type, adaptor state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int ADDR_WIDTH  = 32;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;

    typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adaptor_state_t;

    // Clears the byte-offset bits so the burst address is line aligned.
    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_beat_buffer.sv
// ============================================================================
// Module      : line_beat_buffer
// Description : Line-wide register with per-beat write, full-line load and
//               indexed beat read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_beat_buffer
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_en,
    input  logic [LINE_WIDTH-1:0]  load_line,
    input  logic                   beat_we,
    input  beat_idx_t              wr_idx,
    input  logic [BURST_WIDTH-1:0] beat_in,
    input  beat_idx_t              rd_idx,
    output logic [BURST_WIDTH-1:0] beat_out,
    output logic [LINE_WIDTH-1:0]  line
);

    logic [BURST_WIDTH-1:0] r_beats [BEATS];

    // A full-line load takes precedence over a single-beat write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < BEATS; b++) begin
                r_beats[b] <= '0;
            end
        end else if (load_en) begin
            for (int b = 0; b < BEATS; b++) begin
                r_beats[b] <= load_line[b*BURST_WIDTH +: BURST_WIDTH];
            end
        end else if (beat_we) begin
            r_beats[wr_idx] <= beat_in;
        end
    end

    assign beat_out = r_beats[rd_idx];

    for (genvar b = 0; b < BEATS; b++) begin : g_pack
        assign line[b*BURST_WIDTH +: BURST_WIDTH] = r_beats[b];
    end

endmodule

`default_nettype wire

// File: rtl/cacheline_adaptor_p.sv
// ============================================================================
// Module      : cacheline_adaptor_p
// Description : Converts single-cycle cache line requests into 4-beat memory
//               bursts; one resp pulse per line transfer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_adaptor_p
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    adaptor_state_t         r_state;
    adaptor_state_t         w_state_nxt;
    beat_idx_t              r_cnt;
    beat_idx_t              w_cnt_nxt;
    beat_idx_t              w_rd_idx;
    logic                   w_last;
    logic                   w_wr_load;
    logic                   w_rd_we;
    logic                   w_read_nxt;
    logic                   w_write_nxt;
    logic                   w_resp_nxt;
    logic [ADDR_WIDTH-1:0]  w_addr_nxt;
    logic [BURST_WIDTH-1:0] w_burst_nxt;
    logic [LINE_WIDTH-1:0]  w_line_nxt;
    logic [BURST_WIDTH-1:0] w_next_beat;
    logic [LINE_WIDTH-1:0]  w_buf_line;
    logic [LINE_WIDTH-1:0]  w_assembled;

    assign w_last   = (r_cnt == beat_idx_t'(BEATS - 1));
    assign w_rd_idx = r_cnt + 1'b1;

    // Shared by both directions: reads assemble into it, writes park the line
    // in it. line_o is a separate register so writes never disturb it.
    line_beat_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (w_wr_load),
        .load_line (line_i),
        .beat_we   (w_rd_we),
        .wr_idx    (r_cnt),
        .beat_in   (burst_i),
        .rd_idx    (w_rd_idx),
        .beat_out  (w_next_beat),
        .line      (w_buf_line)
    );

    // The beat arriving this cycle is not yet in the buffer; splice it in.
    always_comb begin
        w_assembled = w_buf_line;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_idx_t'(b) == r_cnt) begin
                w_assembled[b*BURST_WIDTH +: BURST_WIDTH] = burst_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_load   = 1'b0;
        w_rd_we     = 1'b0;
        w_read_nxt  = read_o;
        w_write_nxt = write_o;
        w_resp_nxt  = 1'b0;
        w_addr_nxt  = address_o;
        w_burst_nxt = burst_o;
        w_line_nxt  = line_o;

        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_wr_load   = 1'b1;
                    w_addr_nxt  = line_align(address_i);
                    w_burst_nxt = line_i[BURST_WIDTH-1:0];
                    w_write_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = WR_BURST;
                end else if (read_i) begin
                    w_addr_nxt  = line_align(address_i);
                    w_read_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RD_BURST;
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    w_rd_we = 1'b1;
                    if (w_last) begin
                        w_line_nxt  = w_assembled;
                        w_read_nxt  = 1'b0;
                        w_resp_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            WR_BURST: begin
                if (resp_i) begin
                    if (w_last) begin
                        w_write_nxt = 1'b0;
                        w_resp_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_burst_nxt = w_next_beat;
                    end
                end
            end
            DONE: begin
                // Controller still holds its request here; do not sample it.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
            address_o <= '0;
            burst_o   <= '0;
            line_o    <= '0;
        end else begin
            read_o    <= w_read_nxt;
            write_o   <= w_write_nxt;
            resp_o    <= w_resp_nxt;
            address_o <= w_addr_nxt;
            burst_o   <= w_burst_nxt;
            line_o    <= w_line_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cacheline_adaptor_p.sv
// ============================================================================
// Module      : tb_cacheline_adaptor_p
// Description : Self-checking bench for cacheline_adaptor_p; transaction-level
//               reference model with randomized data, addresses and stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cacheline_adaptor_p;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the controller should currently see on line_o.
    logic [255:0] model_line = '0;
    logic [63:0]  tb_beats [4];
    int           tb_gaps  [4];

    cacheline_adaptor_p dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_read_o", read_o, 0);
            check("idle_write_o", write_o, 0);
            check("idle_resp_o", resp_o, 0);
            check("idle_line_o", line_o, model_line);
        end
    endtask

    task automatic rand_gaps(input int max_gap);
        for (int k = 0; k < 4; k++) tb_gaps[k] = int'($urandom_range(max_gap));
    endtask

    // Entered at a negedge: this cycle is cycle 0 of the request.
    task automatic run_read(input logic [31:0] addr);
        logic [255:0] exp_line;
        exp_line = '0;
        read_i = 1'b1; write_i = 1'b0; address_i = addr; resp_i = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < tb_gaps[k]; s++) begin
                check("rd_stall_read_o", read_o, 1);
                check("rd_stall_resp_o", resp_o, 0);
                resp_i = 1'b0; burst_i = {$urandom, $urandom};
                @(negedge clk);
            end
            check("rd_read_o", read_o, 1);
            check("rd_write_o", write_o, 0);
            check("rd_address_o", address_o, aligned(addr));
            check("rd_early_resp", resp_o, 0);
            exp_line[64*k +: 64] = tb_beats[k];
            resp_i = 1'b1; burst_i = tb_beats[k];
            @(negedge clk);
        end
        resp_i = 1'b0; burst_i = {$urandom, $urandom};
        check("rd_resp_o", resp_o, 1);
        check("rd_read_drop", read_o, 0);
        check("rd_line_o", line_o, exp_line);
        model_line = exp_line;
        @(negedge clk);
        read_i = 1'b0;
        check("rd_resp_single", resp_o, 0);
        check("rd_no_restart", read_o, 0);
        check("rd_line_hold", line_o, model_line);
    endtask

    task automatic run_write(input logic [255:0] line, input logic [31:0] addr, input bit then_read);
        write_i = 1'b1; read_i = then_read; line_i = line; address_i = addr; resp_i = 1'b0;
        @(negedge clk);
        line_i = rand_line();
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < tb_gaps[k]; s++) begin
                check("wr_stall_write_o", write_o, 1);
                check("wr_stall_burst_o", burst_o, line[64*k +: 64]);
                check("wr_stall_resp_o", resp_o, 0);
                resp_i = 1'b0; burst_i = {$urandom, $urandom};
                @(negedge clk);
            end
            check("wr_write_o", write_o, 1);
            check("wr_read_o", read_o, 0);
            check("wr_burst_o", burst_o, line[64*k +: 64]);
            check("wr_address_o", address_o, aligned(addr));
            check("wr_early_resp", resp_o, 0);
            resp_i = 1'b1; burst_i = {$urandom, $urandom};
            @(negedge clk);
        end
        resp_i = 1'b0;
        check("wr_resp_o", resp_o, 1);
        check("wr_write_drop", write_o, 0);
        check("wr_line_o_kept", line_o, model_line);
        @(negedge clk);
        write_i = 1'b0;
        check("wr_resp_single", resp_o, 0);
        check("wr_no_restart", write_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] wl;
        @(negedge clk);
        @(negedge clk);
        check("rst_read_o", read_o, 0);
        check("rst_write_o", write_o, 0);
        check("rst_resp_o", resp_o, 0);
        check("rst_line_o", line_o, 0);
        check("rst_burst_o", burst_o, 0);
        check("rst_address_o", address_o, 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Back-to-back read.
        for (int k = 0; k < 4; k++) begin
            tb_beats[k] = {60'hAAAA_AAAA_AAAA_AAA, 4'(k)};
            tb_gaps[k]  = 0;
        end
        @(negedge clk);
        run_read(32'h1234_5678);
        idle_cycles(2);

        // Back-to-back write.
        run_write(256'h01234567_89ABCDEF_11223344_55667788_99AABBCC_DDEEFF00_76543210_89ABCDEF,
                  32'hDEAD_BEEF, 1'b0);
        idle_cycles(2);

        // Read with beats on cycles 2,3,6,9.
        tb_gaps[0] = 1; tb_gaps[1] = 0; tb_gaps[2] = 2; tb_gaps[3] = 2;
        for (int k = 0; k < 4; k++) tb_beats[k] = {$urandom, $urandom};
        run_read(32'h0000_1F3F);
        idle_cycles(3);

        // Reset after two beats of a read.
        read_i = 1'b1; address_i = 32'hCAFE_0040;
        @(negedge clk);
        resp_i = 1'b1; burst_i = 64'h1111_2222_3333_4444;
        @(negedge clk);
        burst_i = 64'h5555_6666_7777_8888;
        @(negedge clk);
        resp_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_read_o", read_o, 0);
        check("abort_write_o", write_o, 0);
        check("abort_resp_o", resp_o, 0);
        check("abort_line_o", line_o, 0);
        check("abort_burst_o", burst_o, 0);
        check("abort_address_o", address_o, 0);
        read_i = 1'b0;
        model_line = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
        for (int k = 0; k < 4; k++) begin
            tb_beats[k] = {$urandom, $urandom};
            tb_gaps[k]  = 0;
        end
        @(negedge clk);
        run_read(32'h0BAD_F00D);
        idle_cycles(1);

        // Both requests high: write first, then the read.
        rand_gaps(2);
        run_write(rand_line(), 32'h4000_0010, 1'b1);
        rand_gaps(2);
        for (int k = 0; k < 4; k++) tb_beats[k] = {$urandom, $urandom};
        run_read(32'h4000_0010);
        idle_cycles(2);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            rand_gaps(3);
            if ($urandom_range(1) == 1) begin
                wl = rand_line();
                run_write(wl, $urandom, 1'b0);
            end else begin
                for (int k = 0; k < 4; k++) tb_beats[k] = {$urandom, $urandom};
                run_read($urandom);
            end
            idle_cycles(int'($urandom_range(2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
